fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 117 +++++++++++
 tb/tb_fetch_queue.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : First-word-fall-through FIFO between the fetch and decode
//               stages.  It holds {PC, instruction} pairs, keeps the decode
//               stage fed while decode stalls, and discards its contents on
//               a redirect (Flush).  Compile-time option: define the macro
//               FETCH_QUEUE_NOP_EN to present addi x0,x0,0 (32'h00000013)
//               on InstrD while the queue is empty; otherwise InstrD is zero
//               when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int WIDTH = 32,   // PC width
    parameter int DEPTH = 2     // entry count, power of two and >= 2
) (
    input  logic                     clk,
    input  logic                     rst,       // asynchronous, active low
    input  logic [WIDTH-1:0]         PCF,
    input  logic [31:0]              InstrF,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic                     Stall,
    input  logic                     Flush,
    output logic [WIDTH-1:0]         PCD,
    output logic [31:0]              InstrD,
    output logic [WIDTH-1:0]         PCPlus4D,
    output logic                     ValidD,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL    = (c_PTR_W+1)'(DEPTH);
    localparam logic [c_PTR_W:0]   c_CNT_ONE = (c_PTR_W+1)'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [WIDTH-1:0]   c_PC_STEP = WIDTH'(4);
`ifdef FETCH_QUEUE_NOP_EN
    localparam logic [31:0]        c_IDLE_INSTR = 32'h0000_0013;
`else
    localparam logic [31:0]        c_IDLE_INSTR = 32'h0000_0000;
`endif

    // Storage is deliberately not reset; every read is masked by w_valid.
    logic [WIDTH-1:0]   r_pc_mem    [DEPTH];
    logic [31:0]        r_instr_mem [DEPTH];

    // Pointers are exactly log2(DEPTH) bits, so they wrap DEPTH-1 -> 0 on
    // their own.  Count carries the extra bit that tells full from empty.
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic [c_PTR_W:0]   w_count_nxt;

    logic               w_valid;
    logic               w_ready;
    logic               w_push;
    logic               w_pop;
    logic [WIDTH-1:0]   w_head_pc;
    logic [31:0]        w_head_instr;

    assign w_valid      = (r_count != '0);
    assign w_ready      = (r_count != c_FULL);
    // Flush wins over both sides, so neither handshake fires during a redirect.
    assign w_push       = InValid && w_ready && !Flush;
    assign w_pop        = w_valid && !Stall && !Flush;
    assign w_head_pc    = r_pc_mem[r_rd_ptr];
    assign w_head_instr = r_instr_mem[r_rd_ptr];

    // Occupancy update: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_CNT_ONE;
            2'b01:   w_count_nxt = r_count - c_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointer and occupancy registers; reset and flush both empty the queue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (Flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= w_count_nxt;
        end
    end

    // Entry storage write on an accepted push.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= PCF;
            r_instr_mem[r_wr_ptr] <= InstrF;
        end
    end

    // Head presentation: outputs are masked so stale storage never leaks.
    assign ValidD   = w_valid;
    assign InReady  = w_ready;
    assign Count    = r_count;
    assign PCD      = w_valid ? w_head_pc : '0;
    assign PCPlus4D = w_valid ? (w_head_pc + c_PC_STEP) : '0;
    assign InstrD   = w_valid ? w_head_instr : c_IDLE_INSTR;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue: table-driven directed
//               vectors, hand-written multi-cycle sequences (async reset,
//               wrap-around) and randomized traffic against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int c_WIDTH = 32;
    localparam int c_DEPTH = 2;
`ifdef FETCH_QUEUE_NOP_EN
    localparam logic [31:0] c_IDLE = 32'h0000_0013;
`else
    localparam logic [31:0] c_IDLE = 32'h0000_0000;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [31:0]        PCF = '0;
    logic [31:0]        InstrF = '0;
    logic               InValid = 1'b0;
    logic               InReady;
    logic               Stall = 1'b0;
    logic               Flush = 1'b0;
    logic [31:0]        PCD;
    logic [31:0]        InstrD;
    logic [31:0]        PCPlus4D;
    logic               ValidD;
    logic [1:0]         Count;

    fetch_queue #(.WIDTH(c_WIDTH), .DEPTH(c_DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .PCF      (PCF),
        .InstrF   (InstrF),
        .InValid  (InValid),
        .InReady  (InReady),
        .Stall    (Stall),
        .Flush    (Flush),
        .PCD      (PCD),
        .InstrD   (InstrD),
        .PCPlus4D (PCPlus4D),
        .ValidD   (ValidD),
        .Count    (Count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        stall;
        logic        flush;
        int          e_cnt;
        logic        e_valid;
        logic        e_ready;
        logic [31:0] e_pcd;
        logic [31:0] e_instr;
        logic [31:0] e_ppc;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t mq[$];

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return {pc[15:0] ^ 16'h5A5A, 16'hBEEF};
    endfunction

    function automatic vec_t mk(input logic iv, input logic [31:0] pc,
                                input logic st, input logic fl,
                                input int cnt, input logic [31:0] epc);
        vec_t v;
        v.iv      = iv;
        v.pc      = pc;
        v.instr   = ins(pc);
        v.stall   = st;
        v.flush   = fl;
        v.e_cnt   = cnt;
        v.e_valid = (cnt != 0);
        v.e_ready = (cnt != c_DEPTH);
        v.e_pcd   = (cnt != 0) ? epc : 32'h0;
        v.e_instr = (cnt != 0) ? ins(epc) : c_IDLE;
        v.e_ppc   = (cnt != 0) ? epc + 32'd4 : 32'h0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int cnt, input logic valid,
                             input logic ready, input logic [31:0] pcd,
                             input logic [31:0] instr, input logic [31:0] ppc);
        chk({tag, ".Count"},    64'(Count),    64'(cnt));
        chk({tag, ".ValidD"},   64'(ValidD),   64'(valid));
        chk({tag, ".InReady"},  64'(InReady),  64'(ready));
        chk({tag, ".PCD"},      64'(PCD),      64'(pcd));
        chk({tag, ".InstrD"},   64'(InstrD),   64'(instr));
        chk({tag, ".PCPlus4D"}, 64'(PCPlus4D), 64'(ppc));
    endtask

    task automatic check_empty(input string tag);
        check_all(tag, 0, 1'b0, 1'b1, 32'h0, c_IDLE, 32'h0);
    endtask

    // One clock of randomized traffic: model the edge from the rules, then compare.
    task automatic model_cycle(input int idx);
        logic m_ready;
        logic m_valid;
        logic m_push;
        logic m_pop;
        ent_t e;
        m_ready = (mq.size() != c_DEPTH);
        m_valid = (mq.size() != 0);
        m_push  = InValid && m_ready && !Flush;
        m_pop   = m_valid && !Stall && !Flush;
        e.pc    = PCF;
        e.instr = InstrF;
        @(posedge clk);
        if (Flush) begin
            mq.delete();
        end else begin
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back(e);
        end
        #1;
        if (mq.size() != 0)
            check_all($sformatf("rnd%0d", idx), mq.size(), 1'b1, mq.size() != c_DEPTH,
                      mq[0].pc, mq[0].instr, mq[0].pc + 32'd4);
        else
            check_empty($sformatf("rnd%0d", idx));
    endtask

    vec_t vecs[14];

    initial begin
        // Directed table, starting from an empty queue.
        vecs[0]  = mk(1, 32'h0,        1, 0, 1, 32'h0);        // fill with stall
        vecs[1]  = mk(1, 32'h4,        1, 0, 2, 32'h0);        // full
        vecs[2]  = mk(1, 32'h8,        1, 0, 2, 32'h0);        // push while full ignored
        vecs[3]  = mk(0, 32'h0,        0, 0, 1, 32'h4);        // drain
        vecs[4]  = mk(0, 32'h0,        0, 0, 0, 32'h0);        // empty
        vecs[5]  = mk(1, 32'h100,      0, 0, 1, 32'h100);      // streaming
        vecs[6]  = mk(1, 32'h104,      0, 0, 1, 32'h104);
        vecs[7]  = mk(1, 32'h108,      0, 0, 1, 32'h108);
        vecs[8]  = mk(0, 32'h0,        0, 0, 0, 32'h0);
        vecs[9]  = mk(1, 32'h300,      1, 0, 1, 32'h300);      // one entry held
        vecs[10] = mk(1, 32'h200,      0, 1, 0, 32'h0);        // flush beats push/pop
        vecs[11] = mk(0, 32'h0,        0, 0, 0, 32'h0);        // 0x200 never shows
        vecs[12] = mk(1, 32'hFFFF_FFFC, 1, 0, 1, 32'hFFFF_FFFC); // PC+4 wraps
        vecs[13] = mk(0, 32'h0,        0, 0, 0, 32'h0);

        // Asynchronous reset assertion between edges.
        #2;
        rst = 1'b0;
        #1;
        check_empty("rst_async");
        @(posedge clk);
        #1;
        check_empty("rst_held");
        rst = 1'b1;
        #1;
        check_empty("rst_release");

        // Table-driven vectors.
        for (int i = 0; i < 14; i++) begin
            InValid = vecs[i].iv;
            PCF     = vecs[i].pc;
            InstrF  = vecs[i].instr;
            Stall   = vecs[i].stall;
            Flush   = vecs[i].flush;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_valid,
                      vecs[i].e_ready, vecs[i].e_pcd, vecs[i].e_instr, vecs[i].e_ppc);
        end
        InValid = 1'b0;
        Stall   = 1'b0;
        Flush   = 1'b0;

        // Reset in the middle of operation with two entries queued.
        Stall   = 1'b1;
        InValid = 1'b1;
        PCF     = 32'h40;
        InstrF  = ins(32'h40);
        @(posedge clk);
        #1;
        PCF     = 32'h44;
        InstrF  = ins(32'h44);
        @(posedge clk);
        #1;
        InValid = 1'b0;
        check_all("mid_full", 2, 1'b1, 1'b0, 32'h40, ins(32'h40), 32'h44);
        #2;
        rst = 1'b0;
        #1;
        check_empty("mid_rst");
        @(posedge clk);
        #1;
        rst   = 1'b1;
        Stall = 1'b0;
        #1;
        check_empty("mid_rst_after");

        // Wrap-around: five back-to-back push/pop pairs through two slots.
        InValid = 1'b1;
        PCF     = 32'h1000;
        InstrF  = ins(32'h1000);
        @(posedge clk);
        #1;
        for (int k = 1; k <= 5; k++) begin
            PCF    = 32'h1000 + 32'(4 * k);
            InstrF = ins(PCF);
            @(posedge clk);
            #1;
            check_all($sformatf("wrap%0d", k), 1, 1'b1, 1'b1, 32'h1000 + 32'(4 * k),
                      ins(32'h1000 + 32'(4 * k)), 32'h1004 + 32'(4 * k));
        end
        InValid = 1'b0;
        @(posedge clk);
        #1;
        check_empty("wrap_end");

        // Randomized traffic against the queue model (queue is empty here).
        mq.delete();
        for (int n = 0; n < 600; n++) begin
            InValid = ($urandom_range(0, 9) < 7);
            Stall   = ($urandom_range(0, 9) < 4);
            Flush   = ($urandom_range(0, 19) == 0);
            PCF     = $urandom();
            InstrF  = $urandom();
            model_cycle(n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
